// File: rtl/netdma_mem_arbiter.sv
// -----------------------------------------------------------------------------
// netdma_mem_arbiter
//
// Shares one Avalon-MM memory port between the netdma TX readmaster (reads
// only) and the RX writemaster (writes only). Arbitration is round-robin.
//
// A TX read holds the port only for its command cycle. An RX write holds it
// until the last beat of its burst is accepted. New read commands are
// throttled so that the number of read beats in flight never exceeds
// MAX_PENDING_READS.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   tx_*                      TX readmaster slave side (address, read,
//                             burstcount, waitrequest, readdata, readdatavalid)
//   rx_*                      RX writemaster slave side (address, write,
//                             writedata, byteenable, burstcount, waitrequest)
//   mem_*                     master side toward the memory interconnect
//   pending_reads_o           read beats requested but not yet returned
//
// Parameters
//   ADDR_W, DATA_W, BURST_W   bus widths
//   MAX_PENDING_READS         read-beat budget; must be >= 2**(BURST_W-1) so
//                             that a maximum-length burst can always issue
//                             once the counter has drained
// -----------------------------------------------------------------------------
module netdma_mem_arbiter #(
  parameter int ADDR_W            = 32,
  parameter int DATA_W            = 64,
  parameter int BURST_W           = 8,
  parameter int MAX_PENDING_READS = 128,
  localparam int PEND_W           = $clog2(MAX_PENDING_READS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  // TX readmaster
  input  logic [ADDR_W-1:0]     tx_address_i,
  input  logic                  tx_read_i,
  input  logic [BURST_W-1:0]    tx_burstcount_i,
  output logic                  tx_waitrequest_o,
  output logic [DATA_W-1:0]     tx_readdata_o,
  output logic                  tx_readdatavalid_o,

  // RX writemaster
  input  logic [ADDR_W-1:0]     rx_address_i,
  input  logic                  rx_write_i,
  input  logic [DATA_W-1:0]     rx_writedata_i,
  input  logic [DATA_W/8-1:0]   rx_byteenable_i,
  input  logic [BURST_W-1:0]    rx_burstcount_i,
  output logic                  rx_waitrequest_o,

  // Memory port
  output logic [ADDR_W-1:0]     mem_address_o,
  output logic [BURST_W-1:0]    mem_burstcount_o,
  output logic [DATA_W-1:0]     mem_writedata_o,
  output logic [DATA_W/8-1:0]   mem_byteenable_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  input  logic                  mem_waitrequest_i,
  input  logic [DATA_W-1:0]     mem_readdata_i,
  input  logic                  mem_readdatavalid_i,

  // Status
  output logic [PEND_W-1:0]     pending_reads_o
);

  // Wide enough to hold pending + a full burst without wrapping.
  localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_READ_CMD    = 2'd1,
    ST_WRITE_BURST = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_last_grant_tx;  // 1: TX had the last grant, 0: RX
  logic [PEND_W-1:0]    r_pending;
  logic [BURST_W-1:0]   r_beats_left;     // beats still owed after the current one

  logic [BURST_W-1:0]   w_tx_eff;
  logic [BURST_W-1:0]   w_rx_eff;
  logic                 w_tx_fit;
  logic                 w_tx_ok;
  logic                 w_in_read;
  logic                 w_in_write;
  logic                 w_read_accept;
  logic                 w_write_accept;
  logic                 w_first_beat;
  logic                 w_burst_done;
  logic [SUM_W-1:0]     w_pending_add;
  logic [SUM_W-1:0]     w_pending_next;

  // ---------------------------------------------------------------------------
  // Burst length normalisation: a burstcount of 0 means a single beat.
  // ---------------------------------------------------------------------------
  assign w_tx_eff = (tx_burstcount_i == '0) ? BURST_W'(1) : tx_burstcount_i;
  assign w_rx_eff = (rx_burstcount_i == '0) ? BURST_W'(1) : rx_burstcount_i;

  // A read may only be granted if its whole burst fits in the read budget.
  assign w_tx_fit = (SUM_W'(r_pending) + SUM_W'(w_tx_eff)) <= SUM_W'(MAX_PENDING_READS);
  assign w_tx_ok  = tx_read_i && w_tx_fit;

  assign w_in_read  = (r_state == ST_READ_CMD);
  assign w_in_write = (r_state == ST_WRITE_BURST);

  assign w_read_accept  = w_in_read  && tx_read_i  && !mem_waitrequest_i;
  assign w_write_accept = w_in_write && rx_write_i && !mem_waitrequest_i;

  // beats_left is 0 between bursts, so 0 inside WRITE_BURST marks the first
  // beat. A later beat is the last one when it is the only beat still owed.
  assign w_first_beat = (r_beats_left == '0);
  assign w_burst_done = w_write_accept &&
                        (w_first_beat ? (w_rx_eff == BURST_W'(1))
                                      : (r_beats_left == BURST_W'(1)));

  // ---------------------------------------------------------------------------
  // Outstanding read counter: add the accepted burst first, then retire one
  // beat per readdatavalid. Applying the add before the decrement lets a
  // return at pending == 0 coincide with an accept without being lost, while
  // a stray return at 0 with no accept saturates.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pending_add  = SUM_W'(r_pending);
    if (w_read_accept) begin
      w_pending_add = SUM_W'(r_pending) + SUM_W'(w_tx_eff);
    end
    w_pending_next = w_pending_add;
    if (mem_readdatavalid_i && (w_pending_add != '0)) begin
      w_pending_next = w_pending_add - SUM_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Grant FSM and its bookkeeping registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_last_grant_tx <= 1'b0;
      r_pending       <= '0;
      r_beats_left    <= '0;
    end else begin
      r_pending <= PEND_W'(w_pending_next);

      case (r_state)
        ST_IDLE: begin
          if (w_tx_ok && rx_write_i) begin
            // Tie: hand the port to whoever did not have it last.
            r_state <= r_last_grant_tx ? ST_WRITE_BURST : ST_READ_CMD;
          end else if (w_tx_ok) begin
            r_state <= ST_READ_CMD;
          end else if (rx_write_i) begin
            // Also reached when TX is requesting but over budget.
            r_state <= ST_WRITE_BURST;
          end
        end

        ST_READ_CMD: begin
          if (w_read_accept) begin
            r_last_grant_tx <= 1'b1;
            r_state         <= ST_IDLE;
          end else if (!tx_read_i) begin
            // Requester withdrew before the memory took the command.
            r_state <= ST_IDLE;
          end
        end

        ST_WRITE_BURST: begin
          // Write gaps (rx_write_i low) simply hold the grant.
          if (w_write_accept) begin
            if (w_burst_done) begin
              r_beats_left    <= '0;
              r_last_grant_tx <= 1'b0;
              r_state         <= ST_IDLE;
            end else if (w_first_beat) begin
              r_beats_left <= w_rx_eff - BURST_W'(1);
            end else begin
              r_beats_left <= r_beats_left - BURST_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command path: a plain mux on the registered state. Outside WRITE_BURST the
  // command fields follow TX so a read is presented without extra delay.
  // ---------------------------------------------------------------------------
  assign mem_address_o    = w_in_write ? rx_address_i    : tx_address_i;
  assign mem_burstcount_o = w_in_write ? rx_burstcount_i : tx_burstcount_i;
  assign mem_writedata_o  = rx_writedata_i;   // only meaningful with mem_write_o
  assign mem_read_o       = w_in_read  && tx_read_i;
  assign mem_write_o      = w_in_write && rx_write_i;

  // Reads use all byte lanes; writes pass the RX byte enables through.
  generate
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_be_lane
      assign mem_byteenable_o[gi] = w_in_write ? rx_byteenable_i[gi] : 1'b1;
    end
  endgenerate

  // Only the granted requester sees the memory's stall; the other is held.
  assign tx_waitrequest_o = w_in_read  ? mem_waitrequest_i : 1'b1;
  assign rx_waitrequest_o = w_in_write ? mem_waitrequest_i : 1'b1;

  // Read return path is independent of the grant.
  assign tx_readdata_o      = mem_readdata_i;
  assign tx_readdatavalid_o = mem_readdatavalid_i;

  assign pending_reads_o = r_pending;

endmodule

// File: tb/tb_netdma_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_netdma_mem_arbiter
//
// Table-driven bench for netdma_mem_arbiter, instantiated with BURST_W = 5 and
// MAX_PENDING_READS = 16 so the read budget can be exhausted with two 8-beat
// bursts. Each table row is one clock cycle: the inputs driven for that cycle
// and the outputs expected while they are applied (pending is the value
// registered at the start of the cycle). A hand-written sequence at the end
// covers reset in the middle of a write burst.
// -----------------------------------------------------------------------------
module tb_netdma_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 5;
  localparam int MAXPR   = 16;
  localparam int PEND_W  = $clog2(MAXPR + 1);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [ADDR_W-1:0]   tx_address_i;
  logic                tx_read_i;
  logic [BURST_W-1:0]  tx_burstcount_i;
  logic                tx_waitrequest_o;
  logic [DATA_W-1:0]   tx_readdata_o;
  logic                tx_readdatavalid_o;
  logic [ADDR_W-1:0]   rx_address_i;
  logic                rx_write_i;
  logic [DATA_W-1:0]   rx_writedata_i;
  logic [DATA_W/8-1:0] rx_byteenable_i;
  logic [BURST_W-1:0]  rx_burstcount_i;
  logic                rx_waitrequest_o;
  logic [ADDR_W-1:0]   mem_address_o;
  logic [BURST_W-1:0]  mem_burstcount_o;
  logic [DATA_W-1:0]   mem_writedata_o;
  logic [DATA_W/8-1:0] mem_byteenable_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                mem_waitrequest_i;
  logic [DATA_W-1:0]   mem_readdata_i;
  logic                mem_readdatavalid_i;
  logic [PEND_W-1:0]   pending_reads_o;

  always #5 clk_i = ~clk_i;

  netdma_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_PENDING_READS(MAXPR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_address_i(tx_address_i), .tx_read_i(tx_read_i), .tx_burstcount_i(tx_burstcount_i),
    .tx_waitrequest_o(tx_waitrequest_o), .tx_readdata_o(tx_readdata_o),
    .tx_readdatavalid_o(tx_readdatavalid_o),
    .rx_address_i(rx_address_i), .rx_write_i(rx_write_i), .rx_writedata_i(rx_writedata_i),
    .rx_byteenable_i(rx_byteenable_i), .rx_burstcount_i(rx_burstcount_i),
    .rx_waitrequest_o(rx_waitrequest_o),
    .mem_address_o(mem_address_o), .mem_burstcount_o(mem_burstcount_o),
    .mem_writedata_o(mem_writedata_o), .mem_byteenable_o(mem_byteenable_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_waitrequest_i(mem_waitrequest_i), .mem_readdata_i(mem_readdata_i),
    .mem_readdatavalid_i(mem_readdatavalid_i), .pending_reads_o(pending_reads_o)
  );

  typedef struct {
    logic               tx_rd;
    logic [BURST_W-1:0] tb;
    logic               rx_w;
    logic [BURST_W-1:0] rb;
    logic               wt;
    logic               rdv;
    logic               e_mr;
    logic               e_mw;
    logic               e_txw;
    logic               e_rxw;
    logic               e_arx;   // command fields expected to come from RX
    logic [PEND_W-1:0]  e_pend;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input int txr, input int tb, input int rxw, input int rb,
                     input int wt, input int rdv, input int mr, input int mw,
                     input int txw, input int rxwt, input int arx, input int pend);
    vec_t v;
    v.tx_rd  = 1'(txr);
    v.tb     = BURST_W'(tb);
    v.rx_w   = 1'(rxw);
    v.rb     = BURST_W'(rb);
    v.wt     = 1'(wt);
    v.rdv    = 1'(rdv);
    v.e_mr   = 1'(mr);
    v.e_mw   = 1'(mw);
    v.e_txw  = 1'(txw);
    v.e_rxw  = 1'(rxwt);
    v.e_arx  = 1'(arx);
    v.e_pend = PEND_W'(pend);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_in(input int txr, input int tb, input int rxw, input int rb,
                        input int wt, input int rdv);
    tx_read_i           = 1'(txr);
    tx_burstcount_i     = BURST_W'(tb);
    rx_write_i          = 1'(rxw);
    rx_burstcount_i     = BURST_W'(rb);
    mem_waitrequest_i   = 1'(wt);
    mem_readdatavalid_i = 1'(rdv);
  endtask

  task automatic chk_ctl(input string tag, input int idx, input int mr, input int mw,
                         input int txw, input int rxw, input int pend);
    chk({tag, ".mem_read"},  idx, 64'(mem_read_o),       64'(mr));
    chk({tag, ".mem_write"}, idx, 64'(mem_write_o),      64'(mw));
    chk({tag, ".tx_wait"},   idx, 64'(tx_waitrequest_o), 64'(txw));
    chk({tag, ".rx_wait"},   idx, 64'(rx_waitrequest_o), 64'(rxw));
    chk({tag, ".pending"},   idx, 64'(pending_reads_o),  64'(pend));
  endtask

  // Hard stop in case something stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BURST_W-1:0] exp_bc;
    logic [ADDR_W-1:0]  exp_addr;
    logic [DATA_W-1:0]  exp_wdata;

    // ---------------- vector table ----------------
    // add(tx_rd,tb, rx_w,rb, wait,rdv,  mem_read,mem_write,tx_wait,rx_wait, from_rx, pending)

    // Single TX read, burst 8: command at cycle 1, counter 8, drains to 0.
    add(1,8, 0,0, 0,0,  0,0,1,1, 0, 0);
    add(1,8, 0,0, 0,0,  1,0,0,1, 0, 0);
    add(0,8, 0,0, 0,1,  0,0,1,1, 0, 8);
    for (int p = 7; p >= 1; p--) add(0,8, 0,0, 0,1, 0,0,1,1, 0, p);
    add(0,8, 0,0, 0,0,  0,0,1,1, 0, 0);

    // Read stalled by memory, then withdrawn: no count change.
    add(1,3, 0,0, 1,0,  0,0,1,1, 0, 0);
    add(1,3, 0,0, 1,0,  1,0,1,1, 0, 0);
    add(0,3, 0,0, 1,0,  0,0,1,1, 0, 0);
    add(0,3, 0,0, 0,0,  0,0,1,1, 0, 0);

    // Both request continuously: RX (last grant was TX), TX, RX, TX.
    add(1,2, 1,4, 0,0,  0,0,1,1, 0, 0);
    for (int k = 0; k < 4; k++) add(1,2, 1,4, 0,0, 0,1,1,0, 1, 0);
    add(1,2, 1,4, 0,0,  0,0,1,1, 0, 0);
    add(1,2, 1,4, 0,0,  1,0,0,1, 0, 0);
    add(1,2, 1,4, 0,1,  0,0,1,1, 0, 2);
    add(1,2, 1,4, 0,1,  0,1,1,0, 1, 1);
    for (int k = 0; k < 3; k++) add(1,2, 1,4, 0,0, 0,1,1,0, 1, 0);
    add(1,2, 1,4, 0,0,  0,0,1,1, 0, 0);
    add(1,2, 1,4, 0,0,  1,0,0,1, 0, 0);
    add(0,2, 0,4, 0,1,  0,0,1,1, 0, 2);
    add(0,2, 0,4, 0,1,  0,0,1,1, 0, 1);

    // RX 4-beat burst with stalls on beats 2/3 and a gap before beat 4,
    // TX requesting throughout but not serviced until the burst ends.
    add(1,1, 1,4, 0,0,  0,0,1,1, 0, 0);
    add(1,1, 1,4, 0,0,  0,1,1,0, 1, 0);
    add(1,1, 1,4, 1,0,  0,1,1,1, 1, 0);
    add(1,1, 1,4, 0,0,  0,1,1,0, 1, 0);
    add(1,1, 1,4, 1,0,  0,1,1,1, 1, 0);
    add(1,1, 1,4, 0,0,  0,1,1,0, 1, 0);
    add(1,1, 0,4, 0,0,  0,0,1,0, 1, 0);
    add(1,1, 1,4, 0,0,  0,1,1,0, 1, 0);
    add(1,1, 0,4, 0,0,  0,0,1,1, 0, 0);
    add(1,1, 0,4, 0,0,  1,0,0,1, 0, 0);
    add(0,1, 0,4, 0,1,  0,0,1,1, 0, 1);

    // Read budget: two bursts of 8 fill it (16 <= 16 allowed), the third
    // waits until 8 beats have returned; RX writes (incl. burstcount 0) proceed.
    add(1,8, 0,0, 0,0,  0,0,1,1, 0, 0);
    add(1,8, 0,0, 0,0,  1,0,0,1, 0, 0);
    add(1,8, 0,0, 0,0,  0,0,1,1, 0, 8);
    add(1,8, 0,0, 0,0,  1,0,0,1, 0, 8);
    add(1,8, 1,1, 0,0,  0,0,1,1, 0, 16);
    add(1,8, 1,1, 0,0,  0,1,1,0, 1, 16);
    add(1,8, 0,1, 0,1,  0,0,1,1, 0, 16);
    add(1,8, 0,1, 0,1,  0,0,1,1, 0, 15);
    add(1,8, 1,0, 0,1,  0,0,1,1, 0, 14);
    add(1,8, 1,0, 0,1,  0,1,1,0, 1, 13);
    for (int p = 12; p >= 9; p--) add(1,8, 0,0, 0,1, 0,0,1,1, 0, p);
    add(1,8, 0,0, 0,0,  0,0,1,1, 0, 8);
    add(1,8, 0,0, 0,0,  1,0,0,1, 0, 8);
    for (int p = 16; p >= 6; p--) add(0,8, 0,0, 0,1, 0,0,1,1, 0, p);

    // Accept coinciding with a return: 5 + 4 - 1 = 8.
    add(1,4, 0,0, 0,0,  0,0,1,1, 0, 5);
    add(1,4, 0,0, 0,1,  1,0,0,1, 0, 5);
    for (int p = 8; p >= 1; p--) add(0,4, 0,0, 0,1, 0,0,1,1, 0, p);
    // Stray return at 0 saturates.
    add(0,4, 0,0, 0,1,  0,0,1,1, 0, 0);
    add(0,4, 0,0, 0,0,  0,0,1,1, 0, 0);

    // TX burstcount 0 counts as one beat.
    add(1,0, 0,0, 0,0,  0,0,1,1, 0, 0);
    add(1,0, 0,0, 0,0,  1,0,0,1, 0, 0);
    add(0,0, 0,0, 0,0,  0,0,1,1, 0, 1);
    add(0,0, 0,0, 0,1,  0,0,1,1, 0, 1);

    // ---------------- reset ----------------
    rst_i           = 1'b1;
    tx_address_i    = 32'h100;
    rx_address_i    = 32'h200;
    rx_writedata_i  = '0;
    rx_byteenable_i = 8'h5A;
    mem_readdata_i  = '0;
    set_in(0,0, 0,0, 0,0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk_ctl("reset", 0, 0,0,1,1, 0);
    rst_i = 1'b0;

    // ---------------- apply table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].tx_rd, vq[i].tb, vq[i].rx_w, vq[i].rb, vq[i].wt, vq[i].rdv);
      rx_address_i   = 32'h200 + ADDR_W'(i * 8);
      rx_writedata_i = 64'hBEEF_0000_0000_0000 | DATA_W'(i);
      mem_readdata_i = 64'h1000 + DATA_W'(i);
      #1;
      exp_bc    = vq[i].e_arx ? vq[i].rb : vq[i].tb;
      exp_addr  = vq[i].e_arx ? (32'h200 + ADDR_W'(i * 8)) : 32'h100;
      exp_wdata = 64'hBEEF_0000_0000_0000 | DATA_W'(i);
      $display("vec %0d tx_rd=%0d tb=%0d rx_w=%0d rb=%0d wait=%0d rdv=%0d -> rd=%0d wr=%0d txw=%0d rxw=%0d bc=%0d pend=%0d",
               i, vq[i].tx_rd, vq[i].tb, vq[i].rx_w, vq[i].rb, vq[i].wt, vq[i].rdv,
               mem_read_o, mem_write_o, tx_waitrequest_o, rx_waitrequest_o,
               mem_burstcount_o, pending_reads_o);
      chk_ctl("vec", i, vq[i].e_mr, vq[i].e_mw, vq[i].e_txw, vq[i].e_rxw, vq[i].e_pend);
      chk("vec.burstcount", i, 64'(mem_burstcount_o),  64'(exp_bc));
      chk("vec.address",    i, 64'(mem_address_o),     64'(exp_addr));
      chk("vec.rdvalid",    i, 64'(tx_readdatavalid_o), 64'(vq[i].rdv));
      chk("vec.rdata",      i, tx_readdata_o,          64'h1000 + 64'(i));
      if (vq[i].e_mw) begin
        chk("vec.wdata", i, mem_writedata_o,       exp_wdata);
        chk("vec.be",    i, 64'(mem_byteenable_o), 64'h5A);
      end
      @(negedge clk_i);
    end

    // ---------------- reset during an 8-beat write ----------------
    rx_address_i   = 32'h300;
    mem_readdata_i = 64'h0;
    set_in(1,4, 0,0, 0,0); #1;                 // IDLE sees TX
    chk_ctl("rst_seq", 0, 0,0,1,1, 0);
    $display("rst_seq 0 tx read request");
    @(negedge clk_i);
    set_in(1,4, 0,0, 0,0); #1;                 // read accepted
    chk_ctl("rst_seq", 1, 1,0,0,1, 0);
    $display("rst_seq 1 read command");
    @(negedge clk_i);
    set_in(0,4, 1,8, 0,0); #1;                 // IDLE sees RX
    chk_ctl("rst_seq", 2, 0,0,1,1, 4);
    $display("rst_seq 2 rx request");
    @(negedge clk_i);
    set_in(0,4, 1,8, 0,0); #1;                 // beat 1
    chk_ctl("rst_seq", 3, 0,1,1,0, 4);
    $display("rst_seq 3 beat 1");
    @(negedge clk_i);
    set_in(0,4, 1,8, 0,0); rst_i = 1'b1; #1;   // beat 2 with reset
    chk_ctl("rst_seq", 4, 0,1,1,0, 4);
    $display("rst_seq 4 beat 2 with reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_readdata_i = 64'hCAFE;
    set_in(0,0, 1,2, 0,1); #1;                 // back in IDLE, late return
    chk_ctl("rst_seq", 5, 0,0,1,1, 0);
    chk("rst_seq.rdvalid", 5, 64'(tx_readdatavalid_o), 64'd1);
    chk("rst_seq.rdata",   5, tx_readdata_o,           64'hCAFE);
    $display("rst_seq 5 idle after reset, late readdatavalid");
    @(negedge clk_i);
    set_in(0,0, 1,2, 0,0); #1;                 // new 2-beat burst, beat 1
    chk_ctl("rst_seq", 6, 0,1,1,0, 0);
    chk("rst_seq.address", 6, 64'(mem_address_o), 64'h300);
    $display("rst_seq 6 new burst beat 1");
    @(negedge clk_i);
    set_in(0,0, 1,2, 0,0); #1;                 // beat 2 ends the burst
    chk_ctl("rst_seq", 7, 0,1,1,0, 0);
    $display("rst_seq 7 new burst beat 2");
    @(negedge clk_i);
    set_in(1,2, 0,0, 0,0); #1;                 // IDLE sees TX
    chk_ctl("rst_seq", 8, 0,0,1,1, 0);
    $display("rst_seq 8 tx request");
    @(negedge clk_i);
    set_in(1,2, 0,0, 0,0); #1;                 // read granted normally
    chk_ctl("rst_seq", 9, 1,0,0,1, 0);
    chk("rst_seq.burstcount", 9, 64'(mem_burstcount_o), 64'd2);
    $display("rst_seq 9 read command");
    @(negedge clk_i);
    set_in(0,0, 0,0, 0,0); #1;
    chk_ctl("rst_seq", 10, 0,0,1,1, 2);
    $display("rst_seq 10 pending after read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
